// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count pulse.
// One-shot or auto-reload interval/timeout generator.
module countdown_timer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             cnt_ena,
    input  logic             auto_reload,
    input  logic             abort,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             busy
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] reload_q;
    logic [WIDTH-1:0] reload_d;
    logic             tc_d;

    logic             lv_zero;
    logic             at_one;
    logic             do_abort;
    logic             do_load;
    logic             do_dec;
    logic             do_exp;

    assign lv_zero = (load_value == '0);
    assign at_one  = (count == WIDTH'(1));

    // RUN-state events, made one-hot so the priority lives here
    assign do_abort = abort;
    assign do_load  = load & ~abort;
    assign do_dec   = cnt_ena & ~load & ~abort & ~at_one;
    assign do_exp   = cnt_ena & ~load & ~abort & at_one;

    // Next-state and next-output decode
    always_comb begin
        state_d  = state_q;
        count_d  = count;
        reload_d = reload_q;
        tc_d     = 1'b0;
        case (state_q)
            IDLE: begin
                if (load) begin
                    count_d  = load_value;
                    reload_d = load_value;
                    if (!lv_zero) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                unique case (1'b1)
                    do_abort: begin
                        count_d = '0;
                        state_d = IDLE;
                    end
                    do_load: begin
                        count_d  = load_value;
                        reload_d = load_value;
                        if (lv_zero) begin
                            state_d = IDLE;
                        end
                    end
                    do_dec: begin
                        count_d = count - WIDTH'(1);
                    end
                    do_exp: begin
                        tc_d = 1'b1;
                        if (auto_reload) begin
                            count_d = reload_q;
                        end else begin
                            count_d = '0;
                            state_d = IDLE;
                        end
                    end
                    default: begin
                        count_d = count;
                    end
                endcase
            end
            default: begin
                state_d = IDLE;
                count_d = '0;
            end
        endcase
    end

    // State, count, reload value and tc registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            count    <= '0;
            reload_q <= '0;
            tc       <= 1'b0;
        end else begin
            state_q  <= state_d;
            count    <= count_d;
            reload_q <= reload_d;
            tc       <= tc_d;
        end
    end

    assign busy = (state_q == RUN);

endmodule

// File: tb/tb_countdown_timer.sv
// Random and directed checks of countdown_timer
// against a behavioural interval model.
module tb_countdown_timer;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_value;
    logic         cnt_ena;
    logic         auto_reload;
    logic         abort;
    logic [W-1:0] count;
    logic         tc;
    logic         busy;

    int n_vec = 0;
    int n_err = 0;
    int n_tc  = 0;

    // model: remaining interval, reload, running flag, tc
    bit         m_run = 1'b0;
    int         m_cnt = 0;
    int         m_rl  = 0;
    bit         m_tc  = 1'b0;

    always #5 clk = ~clk;

    countdown_timer #(.WIDTH(W)) dut (
        .clk         (clk),
        .reset       (reset),
        .load        (load),
        .load_value  (load_value),
        .cnt_ena     (cnt_ena),
        .auto_reload (auto_reload),
        .abort       (abort),
        .count       (count),
        .tc          (tc),
        .busy        (busy)
    );

    task automatic check(input string tag,
                         input int obs,
                         input int exp);
        n_vec++;
        if (obs != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d @%0t",
                     tag, obs, exp, $time);
        end
    endtask

    // Interval rules applied to the sampled inputs
    task automatic model_step();
        int lv;
        lv   = int'(load_value);
        m_tc = 1'b0;
        if (!reset) begin
            m_run = 1'b0;
            m_cnt = 0;
            m_rl  = 0;
        end else if (!m_run) begin
            if (load) begin
                m_cnt = lv;
                m_rl  = lv;
                m_run = (lv != 0);
            end
        end else if (abort) begin
            m_cnt = 0;
            m_run = 1'b0;
        end else if (load) begin
            m_cnt = lv;
            m_rl  = lv;
            m_run = (lv != 0);
        end else if (cnt_ena) begin
            if (m_cnt == 1) begin
                m_tc = 1'b1;
                if (auto_reload) begin
                    m_cnt = m_rl;
                end else begin
                    m_cnt = 0;
                    m_run = 1'b0;
                end
            end else begin
                m_cnt = m_cnt - 1;
            end
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check({tag, ".count"}, int'(count), m_cnt);
        check({tag, ".tc"}, int'(tc), int'(m_tc));
        check({tag, ".busy"}, int'(busy), int'(m_run));
        n_tc += int'(tc);
    endtask

    task automatic idle_in();
        reset       = 1'b1;
        load        = 1'b0;
        load_value  = '0;
        cnt_ena     = 1'b0;
        auto_reload = 1'b0;
        abort       = 1'b0;
    endtask

    task automatic do_load(input int v);
        load       = 1'b1;
        load_value = W'(v);
        step("load");
        load       = 1'b0;
    endtask

    initial begin
        idle_in();

        // reset dominates load/enable
        reset      = 1'b0;
        load       = 1'b1;
        load_value = 16'd5;
        cnt_ena    = 1'b1;
        step("rst");
        step("rst");
        check("rst_count", int'(count), 0);
        idle_in();
        for (int i = 0; i < 4; i++) step("post_rst");
        check("post_rst_count", int'(count), 0);

        // one-shot of 3
        cnt_ena = 1'b1;
        do_load(3);
        check("os_start", int'(count), 3);
        n_tc = 0;
        for (int i = 0; i < 13; i++) step("oneshot");
        check("os_tc_n", n_tc, 1);
        check("os_busy", int'(busy), 0);

        // gated enable, interval 4
        cnt_ena = 1'b0;
        do_load(4);
        n_tc = 0;
        for (int i = 0; i < 12; i++) begin
            cnt_ena = (i % 2 == 0);
            step("gated");
        end
        check("gated_tc_n", n_tc, 1);

        // auto-reload of 2
        auto_reload = 1'b1;
        cnt_ena     = 1'b1;
        do_load(2);
        n_tc = 0;
        for (int i = 0; i < 8; i++) step("ar");
        check("ar_tc_n", n_tc, 4);
        check("ar_busy", int'(busy), 1);
        auto_reload = 1'b0;
        for (int i = 0; i < 3; i++) step("ar_off");
        check("ar_off_busy", int'(busy), 0);
        check("ar_off_count", int'(count), 0);

        // abort beats load at count 1
        cnt_ena = 1'b0;
        do_load(2);
        cnt_ena = 1'b1;
        step("pri_dec");
        check("pri_at1", int'(count), 1);
        abort      = 1'b1;
        load       = 1'b1;
        load_value = 16'd9;
        step("pri_abort");
        check("pri_abort_tc", int'(tc), 0);
        idle_in();

        // load beats expiry at count 1
        do_load(2);
        cnt_ena = 1'b1;
        step("pri_dec2");
        load       = 1'b1;
        load_value = 16'd9;
        step("pri_load");
        check("pri_load_cnt", int'(count), 9);
        check("pri_load_busy", int'(busy), 1);
        idle_in();

        // zero load never runs
        cnt_ena = 1'b1;
        n_tc = 0;
        do_load(0);
        for (int i = 0; i < 5; i++) step("zero");
        check("zero_tc_n", n_tc, 0);

        // reset at count 2
        cnt_ena = 1'b1;
        do_load(5);
        for (int i = 0; i < 3; i++) step("rmid");
        check("rmid_at2", int'(count), 2);
        n_tc  = 0;
        reset = 1'b0;
        step("rmid_rst");
        reset = 1'b1;
        for (int i = 0; i < 4; i++) step("rmid_after");
        check("rmid_tc_n", n_tc, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 99) != 0);
            load        = ($urandom_range(0, 19) == 0);
            abort       = ($urandom_range(0, 39) == 0);
            cnt_ena     = ($urandom_range(0, 9) < 7);
            auto_reload = ($urandom_range(0, 1) == 1);
            load_value  = ($urandom_range(0, 7) == 0)
                          ? 16'd0
                          : W'($urandom_range(1, 6));
            step("rand");
        end

        // full-range interval
        idle_in();
        cnt_ena = 1'b1;
        do_load(16'hFFFF);
        n_tc = 0;
        for (int i = 0; i < 65534; i++) begin
            @(posedge clk);
            model_step();
            #1;
            n_tc += int'(tc);
        end
        check("max_pre_tc_n", n_tc, 0);
        check("max_at1", int'(count), 1);
        step("max_exp");
        check("max_tc", int'(tc), 1);
        check("max_count", int'(count), 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Loadable 16-bit down-counter: the decrementing counterpart to the team's up-counter with terminal count.
- Counts a loaded value down to zero on cnt_ena qualified cycles and pulses tc on expiry.
- Supports one-shot and auto-reload modes.
- Sits beside the up-counter as the interval/timeout generator for control FSMs.

Parameters:
WIDTH, 16, counter and load-value width in bits

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
load  input  1  single-cycle strobe: capture load_value and start counting
load_value  input  WIDTH  start/reload value; 0 means "no interval"
cnt_ena  input  1  decrement qualifier; count advances only when 1
auto_reload  input  1  1 = reload and continue on expiry; 0 = one-shot
abort  input  1  stop immediately, return to IDLE without tc
count  output  WIDTH  current remaining count (registered)
tc  output  1  terminal-count pulse, exactly one cycle per expiry
busy  output  1  1 while in RUN

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-low, sampled on rising clk.
- Reset values:
  - count = 0, tc = 0, busy = 0.
  - Internal reload_reg = 0, state = IDLE.
  - Reset overrides all other inputs in the same cycle.
- All outputs are registered. busy is 1 exactly when state == RUN.
- Default each cycle: tc <= 0. tc is set only as stated below.
- States: IDLE, RUN.
- IDLE:
  - load=1, load_value!=0: count <= load_value, reload_reg <= load_value, go RUN.
  - load=1, load_value==0: count <= 0, reload_reg <= 0, stay IDLE, no tc.
  - Otherwise hold count. cnt_ena and abort have no effect.
- RUN, priority order (highest first):
  1. abort=1: count <= 0, go IDLE, no tc. A same-cycle load is ignored.
  2. load=1: restart. load_value!=0 loads count and reload_reg and stays RUN. load_value==0 gives count <= 0, go IDLE, no tc. A same-cycle decrement/expiry is discarded (no tc).
  3. cnt_ena=1, count>1: count <= count-1.
  4. cnt_ena=1, count==1 (expiry):
     - tc <= 1.
     - auto_reload=1: count <= reload_reg, stay RUN. If reload_reg==1, tc then fires every enabled cycle.
     - auto_reload=0: count <= 0, go IDLE.
  5. cnt_ena=0: hold count, state unchanged.
- Latency:
  - Load of N with cnt_ena held 1: tc is high in the cycle after the N-th enabled edge, i.e. N clocks after the edge that sampled load.
  - busy drops in the same cycle tc rises (one-shot).
- auto_reload is sampled only at the expiry cycle. Changing it mid-interval is legal.
- Arithmetic: unsigned WIDTH-bit. count never wraps below 0; 0 -> all-ones is unreachable by construction.
- Reset mid-RUN: next cycle everything reads reset values. No tc is emitted for the aborted interval.

Test Plan:
- Reset check: reset=0 for 2 cycles with load=1, load_value=5, cnt_ena=1 -> count=0, tc=0, busy=0 throughout. After release with no load, count stays 0.
- One-shot: load_value=3, pulse load, cnt_ena=1 -> count 3,2,1,0. tc=1 only in the cycle count becomes 0, busy 1->0 in that cycle. No further tc over 10 cycles.
- Gated enable: load_value=4, cnt_ena toggling 1,0,1,0,... -> count decrements only on enabled cycles. tc occurs on the 4th enabled edge, exactly one pulse.
- Auto-reload: load_value=2, auto_reload=1, cnt_ena=1 for 8 cycles -> count 2,1,2,1,2,1,... with tc pulse every 2nd cycle (4 pulses) and busy stays 1. Then auto_reload=0 -> next expiry leaves count=0, busy=0.
- Abort/load priority: in RUN at count=1 with cnt_ena=1, assert abort and load (value 9) together -> count=0, IDLE, tc=0. Repeat with load only -> count=9, busy=1, tc=0.
- Boundaries:
  - load_value=0 -> stays IDLE, tc never asserts.
  - load_value=16'hFFFF, cnt_ena=1 -> tc exactly 65535 cycles after load, count=0.
  - reset=0 asserted at count=2 -> reset values next cycle, no tc.
